// File: rtl/prog_loader_if.sv
// Serial program-loader bus: host-side control/serial input plus the
// program-memory write port and status flags driven by the loader.
interface prog_loader_if;
    logic       START;
    logic       RXD;
    logic       WE;
    logic [3:0] WADDR;
    logic [7:0] WDATA;
    logic       CPU_HOLD;
    logic       DONE;
    logic       ERR;

    modport master (
        input  START, RXD,
        output WE, WADDR, WDATA, CPU_HOLD, DONE, ERR
    );

    modport slave (
        output START, RXD,
        input  WE, WADDR, WDATA, CPU_HOLD, DONE, ERR
    );
endinterface

// File: rtl/prog_loader.sv
// Receives 16 instruction bytes over an 8N1 serial line and writes them to
// program memory, holding the CPU in clear until the load completes.
module prog_loader #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic          CLK,
    input  logic          CLR,
    prog_loader_if.master bus
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] FULL_LIM = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LIM = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_EDGE, START_BIT, DATA, STOP_BIT, WRITE, FINISH, ERROR
    } state_t;

    state_t        state, state_n;
    logic          rxd_s1, rxd_s2, rxd_prev;
    logic [TW-1:0] timer;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic [3:0]    addr;
    logic          tick, fall;
    logic          we, cpu_hold, done, err;
    logic [3:0]    waddr;
    logic [7:0]    wdata;

    assign fall = rxd_prev & ~rxd_s2;
    // The start bit is checked at mid-cell; every later sample is one full bit on.
    assign tick = (state == START_BIT) ? (timer == HALF_LIM) : (timer == FULL_LIM);

    always_ff @(posedge CLK) begin
        if (CLR) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (bus.START) state_n = WAIT_EDGE;
            WAIT_EDGE: if (fall) state_n = START_BIT;
            START_BIT: if (tick) state_n = rxd_s2 ? WAIT_EDGE : DATA;
            DATA:      if (tick && bitcnt == 3'd7) state_n = STOP_BIT;
            STOP_BIT:  if (tick) state_n = rxd_s2 ? WRITE : ERROR;
            WRITE:     state_n = (addr == 4'd15) ? FINISH : WAIT_EDGE;
            FINISH:    state_n = IDLE;
            ERROR:     if (bus.START) state_n = WAIT_EDGE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            rxd_s1   <= 1'b1;
            rxd_s2   <= 1'b1;
            rxd_prev <= 1'b1;
            timer    <= '0;
            bitcnt   <= '0;
            shreg    <= '0;
            addr     <= '0;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            rxd_s1   <= bus.RXD;
            rxd_s2   <= rxd_s1;
            rxd_prev <= rxd_s2;

            if (tick || state_n != state) timer <= '0;
            else                          timer <= timer + TW'(1);

            if (state != DATA) bitcnt <= '0;
            else if (tick)     bitcnt <= bitcnt + 3'd1;

            if (state == DATA && tick) shreg <= {rxd_s2, shreg[7:1]};

            if ((state == IDLE || state == ERROR) && state_n == WAIT_EDGE)
                addr <= '0;
            else if (state == WRITE && addr != 4'd15)
                addr <= addr + 4'd1;

            // Outputs are registered from the next state so each one tracks its
            // state exactly, while WADDR/WDATA latch only on entry to WRITE.
            we <= (state_n == WRITE);
            if (state_n == WRITE && state != WRITE) begin
                waddr <= addr;
                wdata <= shreg;
            end
            cpu_hold <= !(state_n == IDLE || state_n == FINISH);
            done     <= (state_n == FINISH);
            err      <= (state_n == ERROR);
        end
    end

    assign bus.WE       = we;
    assign bus.WADDR    = waddr;
    assign bus.WDATA    = wdata;
    assign bus.CPU_HOLD = cpu_hold;
    assign bus.DONE     = done;
    assign bus.ERR      = err;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader at 4 clocks per serial bit.
module tb_prog_loader;

    logic clk = 1'b0;
    logic clr;
    int   n_checks = 0;
    int   n_fail   = 0;

    prog_loader_if bus();

    prog_loader #(.CLKS_PER_BIT(4)) dut (
        .CLK (clk),
        .CLR (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Write/DONE logger, sampled on the falling edge.
    logic [3:0] wr_addr [0:63];
    logic [7:0] wr_data [0:63];
    int   wr_n = 0;
    int   done_n = 0;
    int   hold_bad = 0;
    int   dbl = 0;
    int   done_hold_bad = 0;
    logic we_prev = 1'b0;

    always @(negedge clk) begin
        if (bus.WE === 1'b1) begin
            if (wr_n < 64) begin
                wr_addr[wr_n] = bus.WADDR;
                wr_data[wr_n] = bus.WDATA;
            end
            wr_n++;
            if (bus.CPU_HOLD !== 1'b1) hold_bad++;
            if (we_prev) dbl++;
        end
        we_prev = (bus.WE === 1'b1);
        if (bus.DONE === 1'b1) begin
            done_n++;
            if (bus.CPU_HOLD !== 1'b0) done_hold_bad++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.START = 1'b1;
        tick(1);
        bus.START = 1'b0;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    task automatic drive_cells(input logic [11:0] cells, input int n);
        for (int i = 0; i < n; i++) begin
            bus.RXD = cells[i];
            tick(4);
        end
    endtask

    // start bit, 8 data bits LSB first, stop bit, two idle cells
    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_cells({2'b11, stop, b, 1'b0}, 12);
    endtask

    task automatic test_reset();
        clr = 1'b1;
        tick(2);
        n_checks++; if (bus.WE !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", bus.WE); end
        n_checks++; if (bus.WADDR !== 4'h0) begin n_fail++; $display("FAIL reset_waddr got %h exp 0", bus.WADDR); end
        n_checks++; if (bus.WDATA !== 8'h00) begin n_fail++; $display("FAIL reset_wdata got %h exp 00", bus.WDATA); end
        n_checks++; if (bus.CPU_HOLD !== 1'b0) begin n_fail++; $display("FAIL reset_hold got %b exp 0", bus.CPU_HOLD); end
        n_checks++; if (bus.DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b exp 0", bus.DONE); end
        n_checks++; if (bus.ERR !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b exp 0", bus.ERR); end
        clr = 1'b0;
        tick(1);
    endtask

    task automatic test_full_load();
        int wb, db, hb, xb, dhb;
        do_clr();
        wb = wr_n; db = done_n; hb = hold_bad; xb = dbl; dhb = done_hold_bad;
        pulse_start();
        n_checks++; if (bus.CPU_HOLD !== 1'b1) begin n_fail++; $display("FAIL full_hold_start got %b exp 1", bus.CPU_HOLD); end
        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
        n_checks++; if (wr_n - wb !== 16) begin n_fail++; $display("FAIL full_wr_count got %0d exp 16", wr_n - wb); end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (wr_addr[wb+i] !== 4'(i) || wr_data[wb+i] !== 8'(i)) begin
                n_fail++;
                $display("FAIL full_write[%0d] got addr %h data %h exp addr %h data %h",
                         i, wr_addr[wb+i], wr_data[wb+i], 4'(i), 8'(i));
            end
        end
        n_checks++; if (done_n - db !== 1) begin n_fail++; $display("FAIL full_done_count got %0d exp 1", done_n - db); end
        n_checks++; if (done_hold_bad - dhb !== 0) begin n_fail++; $display("FAIL full_done_hold got %0d cycles with hold high exp 0", done_hold_bad - dhb); end
        n_checks++; if (hold_bad - hb !== 0) begin n_fail++; $display("FAIL full_hold_during_we got %0d bad exp 0", hold_bad - hb); end
        n_checks++; if (dbl - xb !== 0) begin n_fail++; $display("FAIL full_we_width got %0d double pulses exp 0", dbl - xb); end
        n_checks++; if (bus.CPU_HOLD !== 1'b0) begin n_fail++; $display("FAIL full_hold_end got %b exp 0", bus.CPU_HOLD); end
        n_checks++; if (bus.WADDR !== 4'hF || bus.WDATA !== 8'h0F) begin n_fail++; $display("FAIL full_hold_bus got %h/%h exp f/0f", bus.WADDR, bus.WDATA); end
        n_checks++; if (bus.ERR !== 1'b0) begin n_fail++; $display("FAIL full_err got %b exp 0", bus.ERR); end
    endtask

    task automatic test_framing_error();
        int wb;
        do_clr();
        wb = wr_n;
        pulse_start();
        for (int i = 0; i < 3; i++) send_byte(8'(i), 1'b1);
        send_byte(8'h03, 1'b0);
        n_checks++; if (wr_n - wb !== 3) begin n_fail++; $display("FAIL ferr_wr_count got %0d exp 3", wr_n - wb); end
        n_checks++; if (bus.ERR !== 1'b1) begin n_fail++; $display("FAIL ferr_err got %b exp 1", bus.ERR); end
        n_checks++; if (bus.CPU_HOLD !== 1'b1) begin n_fail++; $display("FAIL ferr_hold got %b exp 1", bus.CPU_HOLD); end
        send_byte(8'h55, 1'b1);
        n_checks++; if (wr_n - wb !== 3) begin n_fail++; $display("FAIL ferr_no_write got %0d exp 3", wr_n - wb); end
        n_checks++; if (bus.ERR !== 1'b1) begin n_fail++; $display("FAIL ferr_sticky got %b exp 1", bus.ERR); end
        pulse_start();
        n_checks++; if (bus.ERR !== 1'b0) begin n_fail++; $display("FAIL ferr_clear got %b exp 0", bus.ERR); end
        send_byte(8'hA5, 1'b1);
        n_checks++; if (wr_n - wb !== 4) begin n_fail++; $display("FAIL ferr_resume_count got %0d exp 4", wr_n - wb); end
        n_checks++; if (wr_addr[wb+3] !== 4'h0 || wr_data[wb+3] !== 8'hA5) begin n_fail++; $display("FAIL ferr_resume got addr %h data %h exp 0/a5", wr_addr[wb+3], wr_data[wb+3]); end
    endtask

    task automatic test_false_start();
        int wb;
        do_clr();
        wb = wr_n;
        pulse_start();
        tick(5);
        bus.RXD = 1'b0;
        tick(1);
        bus.RXD = 1'b1;
        tick(20);
        n_checks++; if (wr_n - wb !== 0) begin n_fail++; $display("FAIL fstart_no_write got %0d exp 0", wr_n - wb); end
        n_checks++; if (bus.ERR !== 1'b0) begin n_fail++; $display("FAIL fstart_err got %b exp 0", bus.ERR); end
        n_checks++; if (bus.CPU_HOLD !== 1'b1) begin n_fail++; $display("FAIL fstart_hold got %b exp 1", bus.CPU_HOLD); end
        send_byte(8'h3C, 1'b1);
        n_checks++; if (wr_n - wb !== 1) begin n_fail++; $display("FAIL fstart_count got %0d exp 1", wr_n - wb); end
        n_checks++; if (wr_addr[wb] !== 4'h0 || wr_data[wb] !== 8'h3C) begin n_fail++; $display("FAIL fstart_write got addr %h data %h exp 0/3c", wr_addr[wb], wr_data[wb]); end
    endtask

    task automatic test_mid_reset();
        int wb, db;
        do_clr();
        wb = wr_n; db = done_n;
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(8'(i + 1), 1'b1);
        drive_cells({7'h7F, 5'b1_0110}, 4);
        do_clr();
        n_checks++; if (bus.WE !== 1'b0 || bus.DONE !== 1'b0 || bus.ERR !== 1'b0) begin n_fail++; $display("FAIL mreset_flags got we %b done %b err %b exp 000", bus.WE, bus.DONE, bus.ERR); end
        n_checks++; if (bus.WADDR !== 4'h0 || bus.WDATA !== 8'h00) begin n_fail++; $display("FAIL mreset_bus got %h/%h exp 0/00", bus.WADDR, bus.WDATA); end
        n_checks++; if (bus.CPU_HOLD !== 1'b0) begin n_fail++; $display("FAIL mreset_hold got %b exp 0", bus.CPU_HOLD); end
        bus.RXD = 1'b1;
        tick(60);
        n_checks++; if (wr_n - wb !== 4) begin n_fail++; $display("FAIL mreset_wr_count got %0d exp 4", wr_n - wb); end
        n_checks++; if (done_n - db !== 0) begin n_fail++; $display("FAIL mreset_done got %0d exp 0", done_n - db); end
    endtask

    task automatic test_ignored_start();
        int wb, db;
        do_clr();
        wb = wr_n; db = done_n;
        pulse_start();
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        fork
            send_byte(8'h02, 1'b1);
            begin tick(15); pulse_start(); end
        join
        for (int i = 3; i < 16; i++) send_byte(8'(8'h80 + i), 1'b1);
        n_checks++; if (wr_n - wb !== 16) begin n_fail++; $display("FAIL istart_count got %0d exp 16", wr_n - wb); end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (wr_addr[wb+i] !== 4'(i)) begin
                n_fail++;
                $display("FAIL istart_addr[%0d] got %h exp %h", i, wr_addr[wb+i], 4'(i));
            end
        end
        n_checks++; if (wr_data[wb+2] !== 8'h02 || wr_data[wb+9] !== 8'h89) begin n_fail++; $display("FAIL istart_data got %h/%h exp 02/89", wr_data[wb+2], wr_data[wb+9]); end
        n_checks++; if (done_n - db !== 1) begin n_fail++; $display("FAIL istart_done got %0d exp 1", done_n - db); end
    endtask

    task automatic test_idle_line();
        int wb, db;
        do_clr();
        wb = wr_n; db = done_n;
        bus.RXD = 1'b1;
        pulse_start();
        tick(1000);
        n_checks++; if (bus.CPU_HOLD !== 1'b1) begin n_fail++; $display("FAIL idle_hold got %b exp 1", bus.CPU_HOLD); end
        n_checks++; if (bus.WE !== 1'b0 || wr_n - wb !== 0) begin n_fail++; $display("FAIL idle_we got we %b writes %0d exp 0/0", bus.WE, wr_n - wb); end
        n_checks++; if (bus.ERR !== 1'b0) begin n_fail++; $display("FAIL idle_err got %b exp 0", bus.ERR); end
        n_checks++; if (done_n - db !== 0) begin n_fail++; $display("FAIL idle_done got %0d exp 0", done_n - db); end
    endtask

    initial begin
        bus.START = 1'b0;
        bus.RXD   = 1'b1;
        clr       = 1'b1;
        test_reset();
        test_full_load();
        test_framing_error();
        test_false_start();
        test_mid_reset();
        test_ignored_start();
        test_idle_line();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
